rst_seq_ctrl: RTL and testbench

- Power-on / soft-reset sequencer for ND downstream reset domains.
- Synchronizes the async board reset internally, then releases domain resets one at a time, in order 0..ND-1.
- A fixed delay precedes each release; after each release the block waits for that domain's ready handshake, with a timeout.
- Sits at top level between the board reset pin and per-subsystem nrst inputs; a software reset request tears domains down in reverse order and re-runs the sequence.

---
 rtl/rst_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
//
// Power-on / soft-reset sequencer for ND downstream reset domains.
//
// The board reset (nrst_in) is synchronised internally. Domain resets are
// then released one at a time in order 0..ND-1. Each release is preceded by
// a fixed DLY-cycle wait. After each release the sequencer waits for that
// domain's ready handshake, and gives up after TO cycles. A timeout is
// recorded in a sticky per-domain flag, and the domain is left released.
// A soft-reset request in RUN tears the domains down in reverse order and
// re-runs the sequence.
//
// Ports
//   clk       in   1          system clock
//   nrst_in   in   1          asynchronous active-low board reset
//   sw_rst    in   1          soft-reset request pulse (honoured only in RUN)
//   rdy_in    in   ND         per-domain ready level, asynchronous to clk
//   nrst_out  out  ND         per-domain active-low resets (registered)
//   all_up    out  1          high while in RUN
//   busy      out  1          high in WAIT, ACK or SHUT
//   to_err    out  ND         sticky per-domain ready-timeout flags
//   cur_dom   out  DW         index of the domain currently being sequenced
// ---------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int ND  = 4,    // number of reset domains (>=1)
  parameter int PS  = 2,    // synchroniser stages (>=2)
  parameter int DLY = 16,   // WAIT cycles before each release (>=1)
  parameter int TO  = 255,  // max ACK cycles before timeout (>=1)
  parameter int CW  = 8,    // counter width, must hold max(DLY,TO)-1
  localparam int DW = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic          clk,
  input  logic          nrst_in,
  input  logic          sw_rst,
  input  logic [ND-1:0] rdy_in,
  output logic [ND-1:0] nrst_out,
  output logic          all_up,
  output logic          busy,
  output logic [ND-1:0] to_err,
  output logic [DW-1:0] cur_dom
);

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    WAIT = 3'd1,
    ACK  = 3'd2,
    RUN  = 3'd3,
    SHUT = 3'd4
  } state_t;

  // Counter compare points, sized once so the compares are width-clean.
  localparam logic [CW-1:0] DLY_LAST = CW'(DLY - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO - 1);
  localparam logic [DW-1:0] DOM_LAST = DW'(ND - 1);

  // -------------------------------------------------------------------------
  // Internal reset synchroniser: asserts asynchronously with nrst_in and
  // releases after PS rising edges with nrst_in high. Shifting in 1s means
  // the last stage goes high only once the whole pipe has filled.
  // -------------------------------------------------------------------------
  logic [PS-1:0] rst_pipe_q;
  logic [PS-1:0] rst_pipe_d;
  logic          int_rst_n;

  always_comb begin
    rst_pipe_d = {rst_pipe_q[PS-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      rst_pipe_q <= '0;
    end else begin
      rst_pipe_q <= rst_pipe_d;
    end
  end

  assign int_rst_n = rst_pipe_q[PS-1];

  // -------------------------------------------------------------------------
  // Ready synchronisers. One PS-stage pipe per domain, cleared by the board
  // reset. Only the synchronised rdy_s is used by the sequencer.
  // -------------------------------------------------------------------------
  logic [ND-1:0] rdy_s;

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_rdy_sync
      logic [PS-1:0] rdy_pipe_q;
      logic [PS-1:0] rdy_pipe_d;

      always_comb begin
        rdy_pipe_d = {rdy_pipe_q[PS-2:0], rdy_in[gi]};
      end

      always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
          rdy_pipe_q <= '0;
        end else begin
          rdy_pipe_q <= rdy_pipe_d;
        end
      end

      assign rdy_s[gi] = rdy_pipe_q[PS-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // -------------------------------------------------------------------------
  state_t        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [DW-1:0] cur_dom_q,  cur_dom_d;
  logic [ND-1:0] nrst_out_q, nrst_out_d;
  logic [ND-1:0] to_err_q,   to_err_d;
  logic          all_up_q,   all_up_d;
  logic          busy_q,     busy_d;

  always_comb begin
    logic adv;

    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_dom_d  = cur_dom_q;
    nrst_out_d = nrst_out_q;
    to_err_d   = to_err_q;
    adv        = 1'b0;

    case (state_q)
      HOLD: begin
        // Only reached here once the internal reset has released.
        state_d   = WAIT;
        cnt_d     = '0;
        cur_dom_d = '0;
      end

      WAIT: begin
        if (cnt_q == DLY_LAST) begin
          nrst_out_d[cur_dom_q] = 1'b1;
          cnt_d                 = '0;
          state_d               = ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ACK: begin
        if (rdy_s[cur_dom_q]) begin
          adv = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          // Domain stays released; the timeout is only recorded.
          to_err_d[cur_dom_q] = 1'b1;
          adv                 = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end

        if (adv) begin
          if (cur_dom_q == DOM_LAST) begin
            state_d = RUN;
          end else begin
            cur_dom_d = cur_dom_q + DW'(1);
            cnt_d     = '0;
            state_d   = WAIT;
          end
        end
      end

      RUN: begin
        // sw_rst is only looked at here, so requests in other states are
        // dropped rather than queued. Ready drops are not watched in RUN.
        if (sw_rst) begin
          cur_dom_d = DOM_LAST;
          cnt_d     = '0;
          state_d   = SHUT;
        end
      end

      SHUT: begin
        // Reverse teardown, one domain per cycle.
        nrst_out_d[cur_dom_q] = 1'b0;
        if (cur_dom_q == '0) begin
          cnt_d    = '0;
          to_err_d = '0;
          state_d  = WAIT;
        end else begin
          cur_dom_d = cur_dom_q - DW'(1);
        end
      end

      default: begin
        state_d    = HOLD;
        cnt_d      = '0;
        cur_dom_d  = '0;
        nrst_out_d = '0;
        to_err_d   = '0;
      end
    endcase

    // While the synchronised reset is still active, park in HOLD.
    if (!int_rst_n) begin
      state_d    = HOLD;
      cnt_d      = '0;
      cur_dom_d  = '0;
      nrst_out_d = '0;
      to_err_d   = '0;
    end

    // Status flags are decoded from the next state so they change on the
    // same edge as the state register.
    all_up_d = (state_d == RUN);
    busy_d   = (state_d == WAIT) || (state_d == ACK) || (state_d == SHUT);
  end

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      cur_dom_q  <= '0;
      nrst_out_q <= '0;
      to_err_q   <= '0;
      all_up_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_dom_q  <= cur_dom_d;
      nrst_out_q <= nrst_out_d;
      to_err_q   <= to_err_d;
      all_up_q   <= all_up_d;
      busy_q     <= busy_d;
    end
  end

  assign nrst_out = nrst_out_q;
  assign to_err   = to_err_q;
  assign cur_dom  = cur_dom_q;
  assign all_up   = all_up_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Directed testbench for rst_seq_ctrl with default parameters.
// Each domain's rdy_in is looped back from its own nrst_out, gated by a
// mask. A released domain therefore reports ready straight away unless it
// is masked off. Expected edges are counted from the instant nrst_in rises
// (edge 1 is the first rising clk edge after that).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rst_seq_ctrl;
  localparam int ND  = 4;
  localparam int PS  = 2;
  localparam int DLY = 16;
  localparam int TO  = 255;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          nrst_in = 1'b0;
  logic          sw_rst = 1'b0;
  logic [ND-1:0] rdy_in;
  logic [ND-1:0] nrst_out;
  logic          all_up;
  logic          busy;
  logic [ND-1:0] to_err;
  logic [1:0]    cur_dom;

  logic          loop_en = 1'b0;
  logic [ND-1:0] rdy_mask = '1;
  logic [ND-1:0] rdy_force = '0;

  int edge_cnt = 0;
  int base = 0;
  int w = 0;
  int k = 0;
  int vectors = 0;
  int miscompares = 0;

  rst_seq_ctrl #(.ND(ND), .PS(PS), .DLY(DLY), .TO(TO), .CW(CW)) dut (
    .clk      (clk),
    .nrst_in  (nrst_in),
    .sw_rst   (sw_rst),
    .rdy_in   (rdy_in),
    .nrst_out (nrst_out),
    .all_up   (all_up),
    .busy     (busy),
    .to_err   (to_err),
    .cur_dom  (cur_dom)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign rdy_in = loop_en ? (nrst_out & rdy_mask) : rdy_force;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt - base);
    end
  endtask

  // Advance to 1 ns after absolute edge number e.
  task automatic at(input int e);
    repeat (e - edge_cnt) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while nrst_in is low.
    #2;
    check("rst_nrst_out", nrst_out, 4'b0000);
    check("rst_all_up",   all_up,   1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_to_err",   to_err,   4'b0000);
    check("rst_cur_dom",  cur_dom,  2'd0);

    // rdy_in toggling near clock edges while held in reset.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      rdy_force = ND'($urandom);
      #4.8;
      check("hold_nrst_out", nrst_out, 4'b0000);
      check("hold_busy",     busy,     1'b0);
      #4.9;
      rdy_force = ~rdy_force;
    end

    // ---- First power-up sequence -----------------------------------------
    @(posedge clk);
    #1;
    loop_en = 1'b1;
    nrst_in = 1'b1;
    base = edge_cnt;
    at(base + 2);  check("p1_e2_busy", busy, 1'b0);
    at(base + 3);  check("p1_e3_busy", busy, 1'b1);
    at(base + 18); check("p1_e18", nrst_out, 4'b0000);
    at(base + 19); check("p1_e19", nrst_out, 4'b0001);
                   check("p1_e19_dom", cur_dom, 2'd0);
    at(base + 37); check("p1_e37", nrst_out, 4'b0001);
    at(base + 38); check("p1_e38", nrst_out, 4'b0011);
                   check("p1_e38_dom", cur_dom, 2'd1);
    at(base + 56); check("p1_e56", nrst_out, 4'b0011);
    at(base + 57); check("p1_e57", nrst_out, 4'b0111);
    at(base + 76); check("p1_e76", nrst_out, 4'b1111);
                   check("p1_e76_up", all_up, 1'b0);
    at(base + 78); check("p1_e78_up", all_up, 1'b0);
    at(base + 79); check("p1_e79_up", all_up, 1'b1);
                   check("p1_busy", busy, 1'b0);
                   check("p1_to_err", to_err, 4'b0000);
                   check("p1_dom", cur_dom, 2'd3);

    // ---- Soft reset from RUN, with ignored pulses in WAIT and ACK ---------
    at(base + 85);
    sw_rst = 1'b1;
    k = edge_cnt;
    at(k + 1); sw_rst = 1'b0;
    check("sw_shut_busy", busy, 1'b1);
    check("sw_shut_up",   all_up, 1'b0);
    check("sw_shut_out",  nrst_out, 4'b1111);
    at(k + 2); check("sw_td1", nrst_out, 4'b0111);
    at(k + 3); check("sw_td2", nrst_out, 4'b0011);
    at(k + 4); check("sw_td3", nrst_out, 4'b0001);
    at(k + 5); check("sw_td4", nrst_out, 4'b0000);
               check("sw_td4_dom", cur_dom, 2'd0);
               check("sw_td4_busy", busy, 1'b1);
    w = k + 5;
    at(w + 5); sw_rst = 1'b1;
    at(w + 6); sw_rst = 1'b0;
    check("swwait_out", nrst_out, 4'b0000);
    at(w + 15); check("rs_e15", nrst_out, 4'b0000);
    at(w + 16); check("rs_e16", nrst_out, 4'b0001);
    sw_rst = 1'b1;
    at(w + 17); sw_rst = 1'b0;
    check("swack_out", nrst_out, 4'b0001);
    check("swack_busy", busy, 1'b1);
    at(w + 35); check("rs_e35", nrst_out, 4'b0011);
    at(w + 54); check("rs_e54", nrst_out, 4'b0111);
    at(w + 73); check("rs_e73", nrst_out, 4'b1111);
    at(w + 75); check("rs_e75_up", all_up, 1'b0);
    at(w + 76); check("rs_e76_up", all_up, 1'b1);

    // ---- Domain 1 never ready: timeout path ---------------------------
    at(w + 80);
    rdy_mask = 4'b1101;
    sw_rst = 1'b1;
    k = edge_cnt;
    at(k + 1); sw_rst = 1'b0;
    w = k + 5;
    at(w);       check("to_td_out", nrst_out, 4'b0000);
    at(w + 35);  check("to_d1_rel", nrst_out, 4'b0011);
    at(w + 289); check("to_e289_err", to_err, 4'b0000);
                 check("to_e289_dom", cur_dom, 2'd1);
    at(w + 290); check("to_e290_err", to_err, 4'b0010);
                 check("to_e290_dom", cur_dom, 2'd2);
                 check("to_e290_busy", busy, 1'b1);
    at(w + 305); check("to_e305", nrst_out, 4'b0011);
    at(w + 306); check("to_e306", nrst_out, 4'b0111);
    at(w + 328); check("to_fin_out", nrst_out, 4'b1111);
                 check("to_fin_up", all_up, 1'b1);
                 check("to_fin_err", to_err, 4'b0010);

    // ---- Soft reset clears to_err; then nrst_in glitch mid-ACK of dom 2 ---
    at(w + 335);
    rdy_mask = 4'b1001;
    sw_rst = 1'b1;
    k = edge_cnt;
    at(k + 1); sw_rst = 1'b0;
    at(k + 4); check("clr_keep_err", to_err, 4'b0010);
    at(k + 5); check("clr_err", to_err, 4'b0000);
    w = k + 5;
    at(w + 290); check("gl_d1_err", to_err, 4'b0010);
    at(w + 310); check("gl_pre_out", nrst_out, 4'b0111);
                 check("gl_pre_dom", cur_dom, 2'd2);
    nrst_in = 1'b0;
    #0.5;
    check("gl_out",  nrst_out, 4'b0000);
    check("gl_err",  to_err, 4'b0000);
    check("gl_up",   all_up, 1'b0);
    check("gl_busy", busy, 1'b0);
    check("gl_dom",  cur_dom, 2'd0);
    #0.5;
    nrst_in = 1'b1;
    rdy_mask = '1;
    base = edge_cnt;
    at(base + 18); check("p2_e18", nrst_out, 4'b0000);
    at(base + 19); check("p2_e19", nrst_out, 4'b0001);
    at(base + 38); check("p2_e38", nrst_out, 4'b0011);
    at(base + 57); check("p2_e57", nrst_out, 4'b0111);
    at(base + 76); check("p2_e76", nrst_out, 4'b1111);
    at(base + 78); check("p2_e78_up", all_up, 1'b0);
    at(base + 79); check("p2_e79_up", all_up, 1'b1);
                   check("p2_to_err", to_err, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
